// File: rtl/bk_prefix_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder: bitwise alpha/beta, up-sweep, down-sweep + sum.
// Optional feature: define BK_ADDER_SAT_EN to clamp the sum to the signed range on overflow.
module bk_prefix_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG_W = $clog2(WIDTH);

  logic             adv;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_alpha_q, s1_alpha_d;
  logic [WIDTH-1:0] s1_beta_q, s1_beta_d;
  logic             s1_cin_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_g_q, s2_g_d;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;
  logic [WIDTH-1:0] s2_pbit_q;
  logic             s2_cin_q;

  logic             s3_valid_q;
  logic [WIDTH-1:0] s3_sum_q, s3_sum_d;
  logic             s3_cout_q, s3_cout_d;
  logic             s3_ovf_q, s3_ovf_d;

  logic [WIDTH-1:0] pre_g;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;
  logic             unused_p;

`ifdef BK_ADDER_SAT_EN
  logic             s1_sign_q;
  logic             s2_sign_q;
`endif

  // The whole pipe moves together; a bubble in S3 or a taking consumer frees it.
  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = rst_n && adv;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign s1_alpha_d[gi] = in_a[gi] & in_b[gi];
      assign s1_beta_d[gi]  = in_a[gi] ^ in_b[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_alpha_q <= '0;
      s1_beta_q  <= '0;
      s1_cin_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_alpha_q <= s1_alpha_d;
      s1_beta_q  <= s1_beta_d;
      s1_cin_q   <= in_cin;
    end
  end

  // Up-sweep: carry-in is folded into bit 0 so every group generate already includes it.
  always_comb begin
    s2_g_d    = s1_alpha_q;
    s2_p_d    = s1_beta_q;
    s2_g_d[0] = s1_alpha_q[0] | (s1_beta_q[0] & s1_cin_q);
    for (int k = 0; k < LOG_W; k++) begin
      for (int i = (2 << k) - 1; i < WIDTH; i += (2 << k)) begin
        s2_g_d[i] = s2_g_d[i] | (s2_p_d[i] & s2_g_d[i - (1 << k)]);
        s2_p_d[i] = s2_p_d[i] & s2_p_d[i - (1 << k)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_g_q     <= '0;
      s2_p_q     <= '0;
      s2_pbit_q  <= '0;
      s2_cin_q   <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_g_q     <= s2_g_d;
      s2_p_q     <= s2_p_d;
      s2_pbit_q  <= s1_beta_q;
      s2_cin_q   <= s1_cin_q;
    end
  end

  // Down-sweep: positions not resolved by the up-sweep pull in the prefix just below their group.
  always_comb begin
    pre_g = s2_g_q;
    for (int k = LOG_W - 2; k >= 0; k--) begin
      for (int i = 3 * (1 << k) - 1; i < WIDTH; i += (2 << k)) begin
        pre_g[i] = pre_g[i] | (s2_p_q[i] & pre_g[i - (1 << k)]);
      end
    end
  end

  // Group propagates at already-resolved positions are not needed by the down-sweep.
  assign unused_p = &s2_p_q;

  assign carry     = {pre_g, s2_cin_q};
  assign sum_raw   = s2_pbit_q ^ carry[WIDTH-1:0];
  assign s3_cout_d = carry[WIDTH];
  assign s3_ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef BK_ADDER_SAT_EN
  // Overflow only happens when both operands share a sign, so A's MSB picks the rail.
  always_comb begin
    s3_sum_d = sum_raw;
    if (s3_ovf_d) begin
      s3_sum_d = s2_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign_q <= 1'b0;
      s2_sign_q <= 1'b0;
    end else if (adv) begin
      s1_sign_q <= in_a[WIDTH-1];
      s2_sign_q <= s1_sign_q;
    end
  end
`else
  assign s3_sum_d = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sum_q   <= '0;
      s3_cout_q  <= 1'b0;
      s3_ovf_q   <= 1'b0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_sum_q   <= s3_sum_d;
      s3_cout_q  <= s3_cout_d;
      s3_ovf_q   <= s3_ovf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_sum   = s3_sum_q;
  assign out_cout  = s3_cout_q;
  assign out_ovf   = s3_ovf_q;

endmodule

// File: tb/tb_bk_prefix_adder_pipe.sv
// Bench for bk_prefix_adder_pipe: directed corner cases, backpressure stream and a
// random valid/ready run checked against an a+b+cin queue model.
module tb_bk_prefix_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  bk_prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   bp_mode = 1'b0;
  int   bp_idx = 0;
  bit   last_in_fire;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    res_t       r;
    logic [W:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`ifdef BK_ADDER_SAT_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the model, return 1ns after the rising edge.
  task automatic tick();
    bit   out_fire;
    res_t e;
    #4;
    last_in_fire = (in_valid === 1'b1) && (in_ready === 1'b1);
    out_fire     = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = q[0];
        chk("sum", out_sum, e.sum);
        chk("cout", out_cout, e.cout);
        chk("ovf", out_ovf, e.ovf);
        if (bp_mode && out_fire) begin
          chk("bp_sum_4i", out_sum, 32'(4 * bp_idx));
          bp_idx++;
        end
      end
    end
    if (out_fire && q.size() > 0) void'(q.pop_front());
    if (last_in_fire) q.push_back(model(in_a, in_b, in_cin));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    tick();
    chk({tag, "_lat2_valid"}, out_valid, 0);
    tick();
    chk({tag, "_lat3_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, out_cout, ec);
    chk({tag, "_ovf"}, out_ovf, eo);
    tick();
  endtask

  initial begin
    int sent;
    int acc;
    bit did_rst;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h4321;
    in_cin    = 1'b1;
    out_ready = 1'b1;
    #1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    tick();
    chk("no_out_after_rst", out_valid, 0);

    send_one("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
`ifdef BK_ADDER_SAT_EN
    send_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_one("neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    send_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif

    bp_mode = 1'b1;
    bp_idx  = 0;
    sent    = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid  = (sent < 8);
      in_a      = W'(sent);
      in_b      = W'(3 * sent);
      in_cin    = 1'b0;
      out_ready = !(cyc >= 4 && cyc <= 7);
      #1;
      if (cyc >= 4 && cyc <= 7) chk("bp_in_ready_full", in_ready, 0);
      tick();
      if (last_in_fire) sent++;
      if (bp_idx == 8 && q.size() == 0) break;
    end
    chk("bp_result_count", bp_idx, 8);
    bp_mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    acc     = 0;
    did_rst = 1'b0;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      if (!did_rst && acc >= 5000) begin
        did_rst  = 1'b1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_valid", out_valid, 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin in_a = 16'h7FFF; in_b = W'($urandom); end
        1:       begin in_a = 16'h8000; in_b = 16'h8000 | W'($urandom); end
        2:       begin in_a = 16'hFFFF; in_b = W'($urandom_range(0, 3)); end
        default: begin in_a = W'($urandom); in_b = W'($urandom); end
      endcase
      in_cin    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) acc++;
    end
    chk("rand_beats_accepted", acc, 10000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
